clk_div_ctrl: RTL

CLK_DIV_CTRL -- requirements
Module: clk_div_ctrl

---
 rtl/clk_div_ctrl.sv | 179 +++++++++++++++++
 1 files changed

// File: rtl/clk_div_ctrl.sv
// Programmable clock divider with 50% duty for even and odd ratios and glitch-free ratio switching.
// Optional switch counter enabled by defining CLK_DIV_CTRL_SWCNT_EN.
module clk_div_ctrl #(
    parameter int W       = 4,
    parameter int DEF_DIV = 3
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         en,
    input  logic         cfg_valid,
    input  logic [W-1:0] cfg_div,
    output logic         cfg_ready,
    output logic         cfg_err,
    output logic         busy,
    output logic [W-1:0] cur_div,
    output logic         clk_out,
    output logic [7:0]   sw_cnt
);

    if ((DEF_DIV < 32'sd2) || (DEF_DIV >= (32'sd1 <<< W))) begin : g_def_div_chk
        $error("clk_div_ctrl: DEF_DIV must be >= 2 and < 2**W");
    end

    localparam logic [W-1:0] ZERO = W'(0);
    localparam logic [W-1:0] ONE  = W'(1);
    localparam logic [W-1:0] TWO  = W'(2);
    localparam logic [W-1:0] DEF  = W'(DEF_DIV);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_LOAD  = 2'd3
    } state_t;

    state_t       state_r;
    logic [W-1:0] cnt_r;
    logic [W-1:0] cur_div_r;
    logic [W-1:0] pend_div_r;
    logic         clk_p_r;
    logic         clk_n_r;
    logic         cfg_ready_r;
    logic         cfg_err_r;
    logic         busy_r;

    logic         acc_s;
    logic         bad_s;
    logic         last_s;
    logic [W-1:0] cnt_nxt_s;
    logic [W-1:0] half_s;

    // Request handshake decode and period counter arithmetic
    always_comb begin
        acc_s     = cfg_valid & cfg_ready_r;
        bad_s     = (cfg_div < TWO);
        last_s    = (cnt_r == (cur_div_r - ONE));
        cnt_nxt_s = last_s ? ZERO : (cnt_r + ONE);
        half_s    = cur_div_r >> 1;
    end

    // Control FSM; clk_p is computed from the next count so it changes only on clk posedge
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= ST_IDLE;
            cnt_r       <= ZERO;
            cur_div_r   <= DEF;
            pend_div_r  <= DEF;
            clk_p_r     <= 1'b0;
            cfg_ready_r <= 1'b1;
            cfg_err_r   <= 1'b0;
            busy_r      <= 1'b0;
        end else begin
            cfg_err_r <= acc_s & bad_s;
            case (state_r)
                ST_IDLE: begin
                    cnt_r       <= ZERO;
                    busy_r      <= 1'b0;
                    cfg_ready_r <= 1'b1;
                    if (acc_s && !bad_s) begin
                        cur_div_r <= cfg_div;
                        clk_p_r   <= 1'b0;
                    end else if (en) begin
                        state_r <= ST_RUN;
                        clk_p_r <= 1'b1;
                    end else begin
                        clk_p_r <= 1'b0;
                    end
                end
                ST_RUN: begin
                    if (acc_s && !bad_s) begin
                        // a new ratio wins over en falling in the same cycle
                        pend_div_r  <= cfg_div;
                        state_r     <= ST_DRAIN;
                        cnt_r       <= cnt_nxt_s;
                        clk_p_r     <= (cnt_nxt_s < half_s);
                        busy_r      <= 1'b1;
                        cfg_ready_r <= 1'b0;
                    end else if (!en && last_s) begin
                        state_r     <= ST_IDLE;
                        cnt_r       <= ZERO;
                        clk_p_r     <= 1'b0;
                        busy_r      <= 1'b0;
                        cfg_ready_r <= 1'b1;
                    end else begin
                        cnt_r       <= cnt_nxt_s;
                        clk_p_r     <= (cnt_nxt_s < half_s);
                        busy_r      <= 1'b0;
                        cfg_ready_r <= 1'b1;
                    end
                end
                ST_DRAIN: begin
                    busy_r      <= 1'b1;
                    cfg_ready_r <= 1'b0;
                    if (last_s) begin
                        state_r <= ST_LOAD;
                        cnt_r   <= ZERO;
                        clk_p_r <= 1'b0;
                    end else begin
                        cnt_r   <= cnt_nxt_s;
                        clk_p_r <= (cnt_nxt_s < half_s);
                    end
                end
                ST_LOAD: begin
                    cur_div_r   <= pend_div_r;
                    cnt_r       <= ZERO;
                    busy_r      <= 1'b0;
                    cfg_ready_r <= 1'b1;
                    if (en) begin
                        state_r <= ST_RUN;
                        clk_p_r <= 1'b1;
                    end else begin
                        state_r <= ST_IDLE;
                        clk_p_r <= 1'b0;
                    end
                end
                default: begin
                    state_r     <= ST_IDLE;
                    cnt_r       <= ZERO;
                    clk_p_r     <= 1'b0;
                    busy_r      <= 1'b0;
                    cfg_ready_r <= 1'b1;
                end
            endcase
        end
    end

    // Half-cycle delayed copy of clk_p that stretches the high phase for odd ratios
    always_ff @(negedge clk or negedge rst_n) begin
        if (!rst_n) begin
            clk_n_r <= 1'b0;
        end else begin
            clk_n_r <= clk_p_r & cur_div_r[0];
        end
    end

`ifdef CLK_DIV_CTRL_SWCNT_EN
    logic [7:0] sw_cnt_r;

    // Saturating count of completed ratio switches (DRAIN -> LOAD)
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sw_cnt_r <= 8'd0;
        end else if ((state_r == ST_DRAIN) && last_s && (sw_cnt_r != 8'hFF)) begin
            sw_cnt_r <= sw_cnt_r + 8'd1;
        end
    end

    assign sw_cnt = sw_cnt_r;
`else
    assign sw_cnt = 8'd0;
`endif

    assign clk_out   = clk_p_r | clk_n_r;
    assign cfg_ready = cfg_ready_r;
    assign cfg_err   = cfg_err_r;
    assign busy      = busy_r;
    assign cur_div   = cur_div_r;

endmodule
